// File: rtl/interleaved_addr_gen.sv
// Purpose: interleaved lane address generator; walks a counter from first to last
//          (one-shot or wrapping) and expands it into LANES addresses {cnt, k}.
// Latency: first beat valid the cycle after an accepted start; one beat per accepted handshake.
// Backpressure: out_valid/out_ready; addr holds stable while out_valid is high and out_ready low.
//
// Ports:
//   clk, reset (async, active-low)
//   start, abort, cfg_first, cfg_last, cfg_wrap : run control and configuration
//   addr (LANES x ADDR_W packed, lane k at [k*ADDR_W +: ADDR_W]), out_valid, out_ready
//   busy, done (one-cycle end-of-run pulse), cfg_err (sticky until next good start)
//   beat_cnt : accepted-beat counter, present only with INTERLEAVED_ADDR_GEN_BEAT_CNT_EN defined
module interleaved_addr_gen #(
    parameter int LANES  = 2,
    parameter int ADDR_W = 14,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 0,
    localparam int CNT_W = ADDR_W - LW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CNT_W-1:0]          cfg_first,
    input  logic [CNT_W-1:0]          cfg_last,
    input  logic                      cfg_wrap,
    output logic [LANES*ADDR_W-1:0]   addr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
`ifdef INTERLEAVED_ADDR_GEN_BEAT_CNT_EN
    ,
    output logic [CNT_W:0]            beat_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            last_q  <= last_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    // Abort is checked before the state decode so it overrides a start or a beat
    // in the same cycle; cnt keeps its value so the last address stays visible.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        last_d  = last_q;
        wrap_d  = wrap_q;
        err_d   = err_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_first <= cfg_last) begin
                            first_d = cfg_first;
                            last_d  = cfg_last;
                            wrap_d  = cfg_wrap;
                            cnt_d   = cfg_first;
                            err_d   = 1'b0;
                            state_d = RUN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        // Increment is never applied at last, so cnt cannot overflow.
                        if (cnt_q == last_q) begin
                            if (wrap_q) begin
                                cnt_d = first_q;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign cfg_err   = err_q;

    // Lane k carries the counter with the lane index in the low LW bits.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (LW == 0) begin : g_single
            assign addr[k*ADDR_W +: ADDR_W] = cnt_q;
        end else begin : g_multi
            assign addr[k*ADDR_W +: ADDR_W] = {cnt_q, LW'(k)};
        end
    end

`ifdef INTERLEAVED_ADDR_GEN_BEAT_CNT_EN
    logic          start_acc;
    logic          beat_acc;
    logic [CNT_W:0] beat_q;

    assign start_acc = !abort && (state_q == IDLE) && start && (cfg_first <= cfg_last);
    assign beat_acc  = !abort && (state_q == RUN) && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q <= '0;
        end else if (start_acc) begin
            beat_q <= '0;
        end else if (beat_acc && (beat_q != '1)) begin
            beat_q <= beat_q + 1'b1;
        end
    end

    assign beat_cnt = beat_q;
`endif

endmodule

// File: tb/tb_interleaved_addr_gen.sv
module tb_interleaved_addr_gen;

    localparam int CW  = 13;   // LANES=2, ADDR_W=14
    localparam int CW4 = 12;   // LANES=4, ADDR_W=14

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Default instance (LANES=2)
    logic          start, abort, cfg_wrap, out_ready;
    logic [CW-1:0] cfg_first, cfg_last;
    logic [27:0]   addr;
    logic          out_valid, busy, done, cfg_err;
`ifdef INTERLEAVED_ADDR_GEN_BEAT_CNT_EN
    logic [CW:0]   beat_cnt;
`endif

    // LANES=4 instance
    logic           s4_start, s4_abort, s4_wrap, s4_ready;
    logic [CW4-1:0] s4_first, s4_last;
    logic [55:0]    addr4;
    logic           s4_valid, s4_busy, s4_done, s4_err;
`ifdef INTERLEAVED_ADDR_GEN_BEAT_CNT_EN
    logic [CW4:0]   beat_cnt4;
`endif

    interleaved_addr_gen #(.LANES(2), .ADDR_W(14)) u_dut (
`ifdef INTERLEAVED_ADDR_GEN_BEAT_CNT_EN
        .beat_cnt (beat_cnt),
`endif
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cfg_first (cfg_first),
        .cfg_last  (cfg_last),
        .cfg_wrap  (cfg_wrap),
        .addr      (addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    interleaved_addr_gen #(.LANES(4), .ADDR_W(14)) u_dut4 (
`ifdef INTERLEAVED_ADDR_GEN_BEAT_CNT_EN
        .beat_cnt (beat_cnt4),
`endif
        .clk       (clk),
        .reset     (reset),
        .start     (s4_start),
        .abort     (s4_abort),
        .cfg_first (s4_first),
        .cfg_last  (s4_last),
        .cfg_wrap  (s4_wrap),
        .addr      (addr4),
        .out_valid (s4_valid),
        .out_ready (s4_ready),
        .busy      (s4_busy),
        .done      (s4_done),
        .cfg_err   (s4_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint lane2(input logic [27:0] a, input int k);
        return longint'(a[k*14 +: 14]);
    endfunction

    function automatic longint lane4(input logic [55:0] a, input int k);
        return longint'(a[k*14 +: 14]);
    endfunction

    typedef struct {
        int first;
        int last;
        bit wrap;
        int nbeats;       // beats to observe (full span for one-shot)
        int mode;         // 0: ready=1, 1: ready 1-0-0-1, 2: random ready + stray starts
        bit exp_err;
        int exp_last_l0;  // lane0 of last observed beat, -1 if none
    } vec_t;

    // Reference: beat i of a run addresses count first + (i mod span); lane k = count*LANES + k.
    task automatic do_run(input int first, input int last, input bit wrap, input int nbeats,
                          input int mode, input bit exp_err, output int last_l0);
        int          span, got, cyc, e;
        bit          r, hv, ok;
        logic [27:0] held;
        last_l0 = -1;
        @(negedge clk);
        cfg_first = CW'(first);
        cfg_last  = CW'(last);
        cfg_wrap  = wrap;
        start     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (exp_err) begin
            chk("cfg_err_set", cfg_err, 1);
            ok = 1'b1;
            for (int i = 0; i < 6; i++) begin
                if (out_valid || busy) ok = 1'b0;
                @(negedge clk);
            end
            chk("err_no_valid", ok, 1);
            return;
        end
        chk("run_cfg_err_clear", cfg_err, 0);
        chk("run_busy", busy, 1);
        span = last - first + 1;
        got  = 0;
        cyc  = 0;
        hv   = 1'b0;
        held = '0;
        while (got < nbeats) begin
            if (cyc > 0) @(negedge clk);
            if (cyc >= 20000) begin
                chk("beat_timeout", got, nbeats);
                break;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (mode == 2) begin
                start     = ($urandom_range(0, 3) == 0);
                cfg_first = CW'($urandom);
                cfg_last  = CW'($urandom);
                cfg_wrap  = 1'($urandom_range(0, 1));
            end
            if (hv) chk("stall_hold", addr, held);
            if (!out_valid) begin
                chk("valid_during_run", out_valid, 1);
                break;
            end
            e = first + (got % span);
            chk("lane0", lane2(addr, 0), e * 2);
            chk("lane1", lane2(addr, 1), e * 2 + 1);
            chk("no_done_in_run", done, 0);
            last_l0 = e * 2;
            hv   = !r;
            held = addr;
            if (r) got++;
            cyc++;
        end
        start = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        if (!wrap) begin
            chk("done_pulse", done, 1);
            chk("busy_after_run", busy, 0);
            chk("valid_after_run", out_valid, 0);
`ifdef INTERLEAVED_ADDR_GEN_BEAT_CNT_EN
            chk("beat_cnt", beat_cnt, nbeats);
`endif
            @(negedge clk);
            chk("done_once", done, 0);
            chk("idle_busy", busy, 0);
        end else begin
            e = first + (got % span);
            chk("wrap_no_done", done, 0);
            chk("wrap_busy", busy, 1);
            abort     = 1'b1;
            start     = 1'b1;
            cfg_first = '0;
            cfg_last  = CW'(1);
            cfg_wrap  = 1'b0;
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            chk("abort_idle", busy, 0);
            chk("abort_no_done", done, 0);
            chk("abort_cnt_held", lane2(addr, 0), e * 2);
            @(negedge clk);
            chk("abort_stays_idle", busy, 0);
            chk("abort_done_low", done, 0);
            chk("abort_err_clear", cfg_err, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   l0, f, sp, nb;
        bit   w;

        tbl[0] = '{512, 1024, 1'b0, 513, 0, 1'b0, 2048};
        tbl[1] = '{512, 1024, 1'b0, 513, 1, 1'b0, 2048};
        tbl[2] = '{5,    7,    1'b1, 8,   0, 1'b0, 12};
        tbl[3] = '{9,    3,    1'b0, 0,   0, 1'b1, -1};
        tbl[4] = '{3,    9,    1'b0, 7,   0, 1'b0, 18};
        tbl[5] = '{8191, 8191, 1'b0, 1,   0, 1'b0, 16382};
        tbl[6] = '{0,    0,    1'b1, 3,   2, 1'b0, 0};

        reset = 1'b0;
        start = 1'b0; abort = 1'b0; cfg_wrap = 1'b0; out_ready = 1'b0;
        cfg_first = '0; cfg_last = '0;
        s4_start = 1'b0; s4_abort = 1'b0; s4_wrap = 1'b0; s4_ready = 1'b0;
        s4_first = '0; s4_last = '0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_lane0", lane2(addr, 0), 0);
        chk("rst_lane1", lane2(addr, 1), 1);
        chk("rst4_lane3", lane4(addr4, 3), 3);
`ifdef INTERLEAVED_ADDR_GEN_BEAT_CNT_EN
        chk("rst_beat_cnt", beat_cnt, 0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_run(tbl[i].first, tbl[i].last, tbl[i].wrap, tbl[i].nbeats,
                   tbl[i].mode, tbl[i].exp_err, l0);
            chk("last_beat_lane0", l0, tbl[i].exp_last_l0);
        end

        // Randomized runs against the reference addressing rule.
        for (int i = 0; i < 10; i++) begin
            f  = int'($urandom_range(0, 8100));
            sp = int'($urandom_range(1, 40));
            w  = 1'($urandom_range(0, 1));
            nb = w ? int'($urandom_range(1, 60)) : sp;
            if ((i % 4 == 3) && sp > 1)
                do_run(f + sp - 1, f, 1'b0, 0, 2, 1'b1, l0);
            do_run(f, f + sp - 1, w, nb, 2, 1'b0, l0);
        end

        // Abort on a cycle that would otherwise accept a beat: cnt must not advance.
        @(negedge clk);
        cfg_first = CW'(0); cfg_last = CW'(50); cfg_wrap = 1'b0; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_lane0", lane2(addr, 0), 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort1_busy", busy, 0);
        chk("abort1_done", done, 0);
        chk("abort1_cnt_held", lane2(addr, 0), 4);
        @(negedge clk);
        chk("abort1_done_later", done, 0);

        // Reset asserted mid-run: outputs drop immediately, no resume without start.
        cfg_first = CW'(10); cfg_last = CW'(50); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_valid", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_lane0", lane2(addr, 0), 0);
        chk("midrst_lane1", lane2(addr, 1), 1);
`ifdef INTERLEAVED_ADDR_GEN_BEAT_CNT_EN
        chk("midrst_beat_cnt", beat_cnt, 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        chk("post_rst_done", done, 0);

        // LANES=4, first == last == 100: one beat on lanes 400..403, then done.
        s4_first = CW4'(100); s4_last = CW4'(100); s4_wrap = 1'b0; s4_ready = 1'b1; s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        chk("l4_valid", s4_valid, 1);
        for (int k = 0; k < 4; k++) chk("l4_lane", lane4(addr4, k), 400 + k);
        @(negedge clk);
        chk("l4_done", s4_done, 1);
        chk("l4_valid_after", s4_valid, 0);
`ifdef INTERLEAVED_ADDR_GEN_BEAT_CNT_EN
        chk("l4_beat_cnt", beat_cnt4, 1);
`endif
        @(negedge clk);
        chk("l4_done_once", s4_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
